// File: rtl/ta_pkg.sv
// Shared types and constants for the Tsetlin-automaton clause controller.
package ta_pkg;

  typedef enum logic [2:0] {IDLE, INFER, REL1, TRAIN, REL2, RESP} ctrl_state_t;

  localparam int   TRAIN_CYCLES = 3;
  localparam logic FB_TYPE_I    = 1'b0;
  localparam logic FB_TYPE_II   = 1'b1;

  // Fibonacci step with taps 16,14,13,11, written in right-shift form.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/ta_lfsr16.sv
// Free-running 16-bit maximal-length LFSR feeding the per-TA random bits.
module ta_lfsr16
  import ta_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] state_q;

  // NOTE: reset is synchronous, so rst only takes effect on a rising clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= lfsr16_next(state_q);
    end
  end

  assign lfsr_o = state_q;

endmodule

// File: rtl/ta_clause_ctrl.sv
// Initiator for a lock-step TA array: inference pass, optional training pass,
// clause reduction and a valid/ready response towards the vote layer.
module ta_clause_ctrl
  import ta_pkg::*;
#(
  parameter int          N_TA      = 8,
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N_TA-1:0] req_literals,
  input  logic            req_train,
  input  logic            req_fb_type,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_clause,
  output logic            rsp_error,
  output logic            ta_enable,
  output logic            ta_training_sel,
  output logic [N_TA-1:0] ta_literal,
  output logic            ta_type_feedback,
  output logic            ta_clause_result,
  output logic [N_TA-1:0] ta_rand,
  input  logic [N_TA-1:0] ta_ready,
  input  logic [N_TA-1:0] ta_done,
  input  logic [N_TA-1:0] ta_result
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  ctrl_state_t      state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       trn_cnt_q;
  logic             train_q;
  logic             clause_q;
  logic             err_q;
  logic [15:0]      lfsr_state;
  logic             unused_lfsr;
  logic             all_done;
  logic             all_ready;
  logic             tmo_hit;

  assign all_done  = &ta_done;
  assign all_ready = &ta_ready;
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

  ta_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr_state)
  );

  for (genvar i = 0; i < N_TA; i++) begin : g_rand
    assign ta_rand[i] = lfsr_state[i % 16];
  end
  // Upper LFSR bits go unobserved when N_TA < 16.
  assign unused_lfsr = ^lfsr_state;

  // NOTE: outputs are registered, so each one is written on the transition into the state that drives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      tmo_q            <= '0;
      trn_cnt_q        <= '0;
      train_q          <= 1'b0;
      clause_q         <= 1'b0;
      err_q            <= 1'b0;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_clause       <= 1'b0;
      rsp_error        <= 1'b0;
      ta_enable        <= 1'b0;
      ta_training_sel  <= 1'b0;
      ta_literal       <= '0;
      ta_type_feedback <= FB_TYPE_I;
      ta_clause_result <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            ta_literal       <= req_literals;
            ta_type_feedback <= req_fb_type;
            train_q          <= req_train;
            req_ready        <= 1'b0;
            ta_enable        <= 1'b1;
            tmo_q            <= '0;
            state_q          <= INFER;
          end
        end
        INFER: begin
          if (all_done || tmo_hit) begin
            clause_q  <= all_done & (&ta_result);
            err_q     <= ~all_done;
            ta_enable <= 1'b0;
            tmo_q     <= '0;
            state_q   <= REL1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        REL1, REL2: begin
          if (all_ready && train_q && state_q == REL1) begin
            ta_enable        <= 1'b1;
            ta_training_sel  <= 1'b1;
            ta_clause_result <= clause_q;
            trn_cnt_q        <= '0;
            tmo_q            <= '0;
            state_q          <= TRAIN;
          end else if (all_ready || tmo_hit) begin
            rsp_valid  <= 1'b1;
            rsp_clause <= clause_q;
            rsp_error  <= err_q | ~all_ready;
            tmo_q      <= '0;
            state_q    <= RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        TRAIN: begin
          // The TAs step through inference, train and feedback; done is not consulted.
          if (trn_cnt_q == 2'(TRAIN_CYCLES - 1)) begin
            ta_enable       <= 1'b0;
            ta_training_sel <= 1'b0;
            tmo_q           <= '0;
            state_q         <= REL2;
          end else begin
            trn_cnt_q <= trn_cnt_q + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid        <= 1'b0;
            rsp_clause       <= 1'b0;
            rsp_error        <= 1'b0;
            err_q            <= 1'b0;
            ta_clause_result <= 1'b0;
            req_ready        <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ta_clause_ctrl.sv
// Directed bench for ta_clause_ctrl with a phase-level reference model checked every cycle.
module tb_ta_clause_ctrl;
  import ta_pkg::*;

  localparam int          N    = 4;
  localparam int          TMO  = 16;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_train, req_fb_type;
  logic [N-1:0] req_literals;
  logic         rsp_valid, rsp_ready, rsp_clause, rsp_error;
  logic         ta_enable, ta_training_sel, ta_type_feedback, ta_clause_result;
  logic [N-1:0] ta_literal, ta_rand, ta_ready, ta_done, ta_result;

  logic [N-1:0] res_cfg, rdy_cfg, stuck_cfg;
  logic         en_d1;
  logic         zero_seen = 1'b0;
  int           total = 0;
  int           bad = 0;

  ta_clause_ctrl #(.N_TA(N), .TIMEOUT(TMO), .LFSR_SEED(SEED)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_literals     (req_literals),
    .req_train        (req_train),
    .req_fb_type      (req_fb_type),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_clause       (rsp_clause),
    .rsp_error        (rsp_error),
    .ta_enable        (ta_enable),
    .ta_training_sel  (ta_training_sel),
    .ta_literal       (ta_literal),
    .ta_type_feedback (ta_type_feedback),
    .ta_clause_result (ta_clause_result),
    .ta_rand          (ta_rand),
    .ta_ready         (ta_ready),
    .ta_done          (ta_done),
    .ta_result        (ta_result)
  );

  always #5 clk = ~clk;

  // Ideal TA array: done two edges after enable rises; results and ready from config.
  assign ta_result = res_cfg;
  assign ta_ready  = rdy_cfg;
  always @(posedge clk) begin
    if (rst) begin
      en_d1   <= 1'b0;
      ta_done <= '0;
    end else begin
      en_d1   <= ta_enable;
      ta_done <= {N{en_d1 & ta_enable}} & ~stuck_cfg;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model. Phases: 0 idle, 1 inference, 2 release, 3 training,
  // 4 release after training, 5 response pending.
  int           m_ph, m_spent;
  logic         m_on = 1'b0;
  logic [N-1:0] m_lit;
  logic         m_fb, m_train, m_clause, m_err, m_cres;
  logic [15:0]  m_lfsr;

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on <= 1'b1; m_ph <= 0; m_spent <= 0; m_lit <= '0; m_fb <= 1'b0;
      m_train <= 1'b0; m_clause <= 1'b0; m_err <= 1'b0; m_cres <= 1'b0;
      m_lfsr <= SEED;
    end else begin
      m_lfsr  <= lfsr_ref(m_lfsr);
      m_spent <= m_spent + 1;
      case (m_ph)
        0: begin
          m_spent <= 0;
          if (req_valid) begin
            m_lit <= req_literals; m_fb <= req_fb_type; m_train <= req_train; m_ph <= 1;
          end
        end
        1: begin
          if (&ta_done) begin
            m_clause <= &ta_result; m_ph <= 2; m_spent <= 0;
          end else if (m_spent + 1 == TMO) begin
            m_err <= 1'b1; m_clause <= 1'b0; m_ph <= 2; m_spent <= 0;
          end
        end
        2, 4: begin
          if (&ta_ready) begin
            if (m_ph == 2 && m_train) begin
              m_ph <= 3; m_cres <= m_clause;
            end else begin
              m_ph <= 5;
            end
            m_spent <= 0;
          end else if (m_spent + 1 == TMO) begin
            m_err <= 1'b1; m_ph <= 5; m_spent <= 0;
          end
        end
        3: if (m_spent + 1 == TRAIN_CYCLES) begin
          m_ph <= 4; m_spent <= 0;
        end
        default: begin
          m_spent <= 0;
          if (rsp_ready) begin
            m_ph <= 0; m_err <= 1'b0; m_cres <= 1'b0;
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] model_ctl();
    logic rv;
    rv = (m_ph == 5);
    return {(m_ph == 1 || m_ph == 3), (m_ph == 3), (m_ph == 0), rv,
            rv & m_clause, rv & m_err, m_cres, m_fb};
  endfunction

  function automatic logic [N-1:0] model_rand();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_lfsr[i % 16];
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      check("ctl", {ta_enable, ta_training_sel, req_ready, rsp_valid, rsp_clause,
                    rsp_error, ta_clause_result, ta_type_feedback}, model_ctl());
      check("literal", ta_literal, m_lit);
      check("rand", ta_rand, model_rand());
      if (dut.lfsr_state == 16'h0000) zero_seen <= 1'b1;
    end
  end

  // Issue one request and return at the negedge where rsp_valid is seen,
  // with per-cycle traces indexed by cycles since the handshake edge.
  task automatic run_req(input logic [N-1:0] lits, input logic tr, input logic fb,
                         output int lat, output logic [31:0] en_tr,
                         output logic [31:0] sel_tr, output logic [31:0] cr_tr);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1'b1);
    req_valid = 1'b1; req_literals = lits; req_train = tr; req_fb_type = fb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; en_tr = '0; sel_tr = '0; cr_tr = '0;
    while (1) begin
      if (lat < 32) begin
        en_tr[lat] = ta_enable; sel_tr[lat] = ta_training_sel; cr_tr[lat] = ta_clause_result;
      end
      if (rsp_valid || lat >= 100) break;
      @(negedge clk);
      lat++;
    end
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_req_ready", req_ready, 1'b1);
    check("post_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, n;
    logic [31:0] en_tr, sel_tr, cr_tr;
    rst = 1'b1; req_valid = 1'b0; req_literals = '0; req_train = 1'b0;
    req_fb_type = 1'b0; rsp_ready = 1'b0;
    res_cfg = '1; rdy_cfg = '1; stuck_cfg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_enable", ta_enable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_lfsr", dut.lfsr_state, 16'hACE1);
    check("rst_rand", ta_rand, 4'h1);
    rst = 1'b0;
    @(negedge clk);
    check("lfsr_step1", dut.lfsr_state, 16'h5670);
    @(negedge clk);
    check("lfsr_step2", dut.lfsr_state, 16'hAB38);

    // Inference only, all results 1.
    run_req(4'hF, 1'b0, FB_TYPE_I, lat, en_tr, sel_tr, cr_tr);
    check("infer_latency", lat, 4);
    check("infer_enable_trace", en_tr, 32'h0000_0007);
    check("infer_sel_trace", sel_tr, 32'h0);
    check("infer_clause", rsp_clause, 1'b1);
    check("infer_error", rsp_error, 1'b0);
    consume();

    // Training, Type I feedback, TA 2 returns 0.
    res_cfg = 4'b1011;
    run_req(4'hF, 1'b1, FB_TYPE_I, lat, en_tr, sel_tr, cr_tr);
    check("train_latency", lat, 8);
    check("train_enable_trace", en_tr, 32'h0000_0077);
    check("train_sel_trace", sel_tr, 32'h0000_0070);
    check("train_cres_trace", cr_tr, 32'h0);
    check("train_clause", rsp_clause, 1'b0);
    check("train_error", rsp_error, 1'b0);
    consume();

    // Training, Type II feedback, clause 1: clause result held from TRAIN entry to response.
    res_cfg = '1;
    run_req(4'hA, 1'b1, FB_TYPE_II, lat, en_tr, sel_tr, cr_tr);
    check("train2_latency", lat, 8);
    check("train2_cres_trace", cr_tr, 32'h0000_01F0);
    check("train2_clause", rsp_clause, 1'b1);
    check("train2_fb", ta_type_feedback, 1'b1);
    consume();
    check("train2_cres_cleared", ta_clause_result, 1'b0);

    // TA 1 never reports done: inference times out after TIMEOUT cycles.
    stuck_cfg = 4'b0010;
    run_req(4'hF, 1'b0, FB_TYPE_I, lat, en_tr, sel_tr, cr_tr);
    check("tmo_latency", lat, 17);
    check("tmo_enable_trace", en_tr, 32'h0000_FFFF);
    check("tmo_error", rsp_error, 1'b1);
    check("tmo_clause", rsp_clause, 1'b0);
    consume();
    stuck_cfg = '0;

    // TA 0 never ready: release times out and training is skipped.
    rdy_cfg = 4'b1110;
    run_req(4'hF, 1'b1, FB_TYPE_II, lat, en_tr, sel_tr, cr_tr);
    check("rel_tmo_latency", lat, 19);
    check("rel_tmo_sel_trace", sel_tr, 32'h0);
    check("rel_tmo_error", rsp_error, 1'b1);
    check("rel_tmo_clause", rsp_clause, 1'b1);
    consume();
    rdy_cfg = '1;

    // Back-pressure with a competing request held upstream.
    run_req(4'hF, 1'b0, FB_TYPE_I, lat, en_tr, sel_tr, cr_tr);
    req_valid = 1'b1; req_literals = 4'h5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_clause", rsp_clause, 1'b1);
      check("bp_rsp_error", rsp_error, 1'b0);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_literal", ta_literal, 4'hF);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_idle_ready", req_ready, 1'b1);
    check("bp_not_accepted", ta_enable, 1'b0);
    check("bp_literal_held", ta_literal, 4'hF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_accepted", ta_enable, 1'b1);
    check("bp_new_literal", ta_literal, 4'h5);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_rsp", rsp_valid, 1'b1);
    consume();

    // Reset asserted in the middle of the training pass.
    req_valid = 1'b1; req_literals = 4'h3; req_train = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!ta_training_sel && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_train", ta_training_sel, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_enable", ta_enable, 1'b0);
    check("mid_rst_sel", ta_training_sel, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_lfsr", dut.lfsr_state, 16'hACE1);
    rst = 1'b0;

    // Full LFSR period from the seed.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (65535) @(negedge clk);
    check("lfsr_period_dut", dut.lfsr_state, 16'hACE1);
    check("lfsr_period_model", m_lfsr, 16'hACE1);
    check("lfsr_no_zero", zero_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
